// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: data width, wait-counter
// width and the responder FSM state encoding.
package dmem_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    DRAIN_WAIT = 2'd2,
    ACK        = 2'd3
  } dmemStateT;

endpackage

// File: rtl/dmem_write_buffer.sv
// Posted-store write buffer: circular FIFO of {word index, data} entries with
// a parallel lookup that returns the youngest valid entry matching an index.
module dmem_write_buffer
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] pushIdx,
  input  logic [DATA_WIDTH-1:0] pushData,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] lookupIdx,
  output logic [CNT_W-1:0]      count,
  output logic [ADDR_WIDTH-1:0] headIdx,
  output logic [DATA_WIDTH-1:0] headData,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hitData
);

  logic [ADDR_WIDTH-1:0] idxMem  [DEPTH];
  logic [DATA_WIDTH-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]      headPtr;
  logic [PTR_W-1:0]      tailPtr;
  logic [PTR_W-1:0]      slot;

  // Entry storage: written at the tail on every push.
  // NOTE: storage arrays carry no reset; validity comes from count alone.
  always_ff @(posedge CLK) begin
    if (push) begin
      idxMem[tailPtr]  <= pushIdx;
      dataMem[tailPtr] <= pushData;
    end
  end

  // Pointer and occupancy bookkeeping; a reset discards every entry.
  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (push) tailPtr <= tailPtr + 1'b1;
      if (pop)  headPtr <= headPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign headIdx  = idxMem[headPtr];
  assign headData = dataMem[headPtr];

  // Scan oldest to youngest so the last valid match left standing is the youngest.
  // NOTE: every output gets a default first, so no latch is inferred.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    slot    = headPtr;
    for (int age = 0; age < DEPTH; age++) begin
      slot = headPtr + PTR_W'(age);
      if ((CNT_W'(age) < count) && (idxMem[slot] == lookupIdx)) begin
        hit     = 1'b1;
        hitData = dataMem[slot];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: Req/Ack load/store handshake, posted stores
// through a write buffer, store-to-load forwarding, and a wait-stated word array.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic                        Req,
  input  logic                        WrEn,
  input  logic [31:0]                 Addr,
  input  logic [DATA_WIDTH-1:0]       WrData,
  output logic [DATA_WIDTH-1:0]       RdData,
  output logic                        Ack,
  output logic                        Busy,
  output logic [$clog2(WBUF_DEPTH):0] WbufCount,
  output logic                        Drained
);

  localparam int CNT_W = $clog2(WBUF_DEPTH) + 1;
  localparam logic [WAIT_CNT_W-1:0] DRAIN_CNT_INIT = WAIT_CNT_W'(WAIT_STATES);
  // A load miss that is sampled counts as its first access cycle.
  localparam logic [WAIT_CNT_W-1:0] LOAD_CNT_INIT =
    (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

  dmemStateT             state;
  logic [WAIT_CNT_W-1:0] waitCnt;
  logic [DATA_WIDTH-1:0] memArray [2**ADDR_WIDTH];

  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [ADDR_WIDTH-1:0] headIdx;
  logic [DATA_WIDTH-1:0] headData;
  logic [DATA_WIDTH-1:0] hitData;
  logic                  hit;
  logic                  unusedAddrBits;

  logic canSample;
  logic drainCommit;
  logic bufFull;
  logic storeAccept;
  logic loadHit;
  logic loadMiss;
  logic startLoad;

  assign wordIdx        = Addr[ADDR_WIDTH+1:2];
  assign unusedAddrBits = ^{Addr[31:ADDR_WIDTH+2], Addr[1:0]};

  // A request is only looked at outside the Ack cycle and outside a load miss.
  assign canSample   = Req && !Ack && ((state == IDLE) || (state == DRAIN_WAIT));
  assign drainCommit = (state == DRAIN_WAIT) && (waitCnt == '0);
  assign bufFull     = (WbufCount == CNT_W'(WBUF_DEPTH));
  // A store to a full buffer slips into the slot freed by a committing drain.
  assign storeAccept = canSample && WrEn && (!bufFull || drainCommit);
  assign loadHit     = canSample && !WrEn && hit;
  assign loadMiss    = canSample && !WrEn && !hit;
  // A miss seen mid-drain waits for the in-flight commit, then starts at once.
  assign startLoad   = loadMiss && ((state == IDLE) || drainCommit);

  assign Busy    = Req && !Ack;
  assign Drained = (WbufCount == '0) && (state == IDLE);

  dmem_write_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (WBUF_DEPTH)
  ) u_wbuf (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (storeAccept),
    .pushIdx   (wordIdx),
    .pushData  (WrData),
    .pop       (drainCommit),
    .lookupIdx (wordIdx),
    .count     (WbufCount),
    .headIdx   (headIdx),
    .headData  (headData),
    .hit       (hit),
    .hitData   (hitData)
  );

  // Array write port: the buffer head lands here when its drain commits.
  always_ff @(posedge CLK) begin
    if (drainCommit && !Reset) begin
      memArray[headIdx] <= headData;
    end
  end

  // Responder FSM with registered Ack and RdData.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      Ack     <= 1'b0;
      RdData  <= '0;
    end else begin
      Ack <= 1'b0;
      if (loadHit) RdData <= hitData;
      if (storeAccept || loadHit) Ack <= 1'b1;

      case (state)
        IDLE: begin
          if (startLoad) begin
            if (WAIT_STATES == 0) begin
              RdData <= memArray[wordIdx];
              Ack    <= 1'b1;
              state  <= ACK;
            end else begin
              state   <= LOAD_WAIT;
              waitCnt <= LOAD_CNT_INIT;
            end
          end else if (storeAccept || loadHit) begin
            state <= ACK;
          end else if (WbufCount != '0) begin
            state   <= DRAIN_WAIT;
            waitCnt <= DRAIN_CNT_INIT;
          end
        end

        DRAIN_WAIT: begin
          if (!drainCommit) begin
            waitCnt <= waitCnt - 1'b1;
          end else if (startLoad) begin
            if (WAIT_STATES == 0) begin
              RdData <= memArray[wordIdx];
              Ack    <= 1'b1;
              state  <= ACK;
            end else begin
              state   <= LOAD_WAIT;
              waitCnt <= LOAD_CNT_INIT;
            end
          end else begin
            state <= IDLE;
          end
        end

        LOAD_WAIT: begin
          if (waitCnt == '0) begin
            RdData <= memArray[wordIdx];
            Ack    <= 1'b1;
            state  <= ACK;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end

        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (WAIT_STATES=2, WBUF_DEPTH=4).
// Each access pushes its expected latency/data to a scoreboard queue that is
// popped when the responder acknowledges.
module tb_dmem_responder;

  localparam int AW = 10;
  localparam int WS = 2;
  localparam int WD = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req;
  logic        WrEn;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic [31:0] RdData;
  logic        Ack;
  logic        Busy;
  logic [$clog2(WD):0] WbufCount;
  logic        Drained;

  typedef struct {
    logic        isLoad;
    logic [31:0] data;
    int          lat;
  } expT;

  expT         sbQ[$];
  int          checkCnt = 0;
  int          passCnt  = 0;
  logic [31:0] lastRd   = '0;
  logic        reqOpen  = 1'b0;

  dmem_responder #(
    .ADDR_WIDTH  (AW),
    .WAIT_STATES (WS),
    .WBUF_DEPTH  (WD)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Req       (Req),
    .WrEn      (WrEn),
    .Addr      (Addr),
    .WrData    (WrData),
    .RdData    (RdData),
    .Ack       (Ack),
    .Busy      (Busy),
    .WbufCount (WbufCount),
    .Drained   (Drained)
  );

  always #5 CLK = ~CLK;

  // Protocol guard: once a request is open, Req must stay high until Ack.
  always @(posedge CLK) begin
    if (!Reset && reqOpen) begin
      assert (Req) else $error("protocol: Req dropped before Ack");
    end
    reqOpen <= Req && !Ack && !Reset;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCnt++;
    if (got !== want) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end else begin
      passCnt++;
    end
  endtask

  // Drive one access at posedge+1, wait for Ack, score it, then release Req
  // after the Ack cycle ends.
  task automatic doAccess(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] expRd, input int expLat, input string tag);
    expT  e;
    int   n;
    int   busyN;
    logic gotAck;
    e.isLoad = !wr;
    e.data   = expRd;
    e.lat    = expLat;
    sbQ.push_back(e);
    Req    = 1'b1;
    WrEn   = wr;
    Addr   = addr;
    WrData = wdata;
    n      = 0;
    busyN  = 0;
    gotAck = 1'b0;
    while (!gotAck && n < 64) begin
      @(negedge CLK);
      if (Busy) busyN++;
      @(posedge CLK);
      #1;
      n++;
      gotAck = Ack;
    end
    check({tag, "_ack"}, 32'(gotAck), 32'd1);
    e = sbQ.pop_front();
    if (gotAck) begin
      check({tag, "_lat"}, n, e.lat);
      check({tag, "_busy_cycles"}, busyN, e.lat);
      check({tag, "_busy_in_ack"}, 32'(Busy), 32'd0);
      if (e.isLoad) begin
        check({tag, "_rd"}, RdData, e.data);
        lastRd = e.data;
      end else begin
        check({tag, "_rd_hold"}, RdData, lastRd);
      end
    end
    @(posedge CLK);
    #1;
    check({tag, "_ack_pulse"}, 32'(Ack), 32'd0);
    Req  = 1'b0;
    WrEn = 1'b0;
  endtask

  task automatic waitDrained(input string tag);
    for (int k = 0; k < 100; k++) begin
      if (Drained) break;
      @(posedge CLK);
      #1;
    end
    check({tag, "_drained"}, 32'(Drained), 32'd1);
  endtask

  initial begin
    Reset  = 1'b1;
    Req    = 1'b0;
    WrEn   = 1'b0;
    Addr   = '0;
    WrData = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_rd", RdData, 32'd0);
    check("rst_count", 32'(WbufCount), 32'd0);
    check("rst_drained", 32'(Drained), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    Reset = 1'b0;

    // 1: array word 0x40 holds 0xDEADBEEF, then a load miss takes WS+1 cycles.
    doAccess(1'b1, 32'h40, 32'hDEADBEEF, '0, 1, "t1_pre");
    waitDrained("t1");
    doAccess(1'b0, 32'h40, '0, 32'hDEADBEEF, WS + 1, "t1_ld");

    // 2: store then forwarded load, both at latency 1.
    doAccess(1'b1, 32'h100, 32'h11111111, '0, 1, "t2_st");
    check("t2_count", 32'(WbufCount), 32'd1);
    doAccess(1'b0, 32'h100, '0, 32'h11111111, 1, "t2_ld");
    waitDrained("t2");

    // 3: two stores to one word; youngest is forwarded, then drained in order.
    doAccess(1'b1, 32'h200, 32'h0000000A, '0, 1, "t3_st_a");
    doAccess(1'b1, 32'h200, 32'h0000000B, '0, 1, "t3_st_b");
    check("t3_count", 32'(WbufCount), 32'd2);
    doAccess(1'b0, 32'h200, '0, 32'h0000000B, 1, "t3_ld_fwd");
    waitDrained("t3");
    doAccess(1'b0, 32'h200, '0, 32'h0000000B, WS + 1, "t3_ld_arr");

    // 4: five back-to-back stores; the fifth waits for the first drain commit.
    waitDrained("t4_pre");
    for (int i = 0; i < 5; i++) begin
      doAccess(1'b1, 32'h400 + 32'(4 * i), 32'hC0DE0000 + 32'(i), '0,
               (i < WD) ? 1 : WS + 2, $sformatf("t4_st%0d", i));
      check($sformatf("t4_count%0d", i), 32'(WbufCount), (i < WD) ? 32'(i + 1) : 32'(WD));
    end
    waitDrained("t4");
    doAccess(1'b0, 32'h400, '0, 32'hC0DE0000, WS + 1, "t4_ld_first");
    doAccess(1'b0, 32'h410, '0, 32'hC0DE0004, WS + 1, "t4_ld_last");

    // 5: load miss sampled one cycle into a drain waits for the commit.
    doAccess(1'b1, 32'h300, 32'h5555AAAA, '0, 1, "t5_st");
    @(posedge CLK);
    #1;
    check("t5_draining", 32'(Drained), 32'd0);
    doAccess(1'b0, 32'h40, '0, 32'hDEADBEEF, 2 * WS + 1, "t5_ld_miss");
    waitDrained("t5");
    doAccess(1'b0, 32'h300, '0, 32'h5555AAAA, WS + 1, "t5_ld_arr");

    // 6: reset mid-drain discards all buffered stores.
    doAccess(1'b1, 32'h40,  32'h00000001, '0, 1, "t6_st0");
    doAccess(1'b1, 32'h100, 32'h00000002, '0, 1, "t6_st1");
    doAccess(1'b1, 32'h200, 32'h00000003, '0, 1, "t6_st2");
    check("t6_count", 32'(WbufCount), 32'd3);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    check("t6_mid_drain", 32'(Drained), 32'd0);
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset  = 1'b0;
    lastRd = '0;
    check("t6_rst_count", 32'(WbufCount), 32'd0);
    check("t6_rst_drained", 32'(Drained), 32'd1);
    check("t6_rst_ack", 32'(Ack), 32'd0);
    check("t6_rst_rd", RdData, 32'd0);
    doAccess(1'b0, 32'h40,  '0, 32'hDEADBEEF, WS + 1, "t6_ld0");
    doAccess(1'b0, 32'h100, '0, 32'h11111111, WS + 1, "t6_ld1");
    doAccess(1'b0, 32'h200, '0, 32'h0000000B, WS + 1, "t6_ld2");

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
